// File: rtl/mux_41_rr_sched_if.sv
// Bus bundle for the round-robin 4:1 mux scheduler: four request/data lanes
// in, one valid/ready beat stream out, plus the grant/select/ack status.
interface mux_41_rr_sched_if #(
  parameter int DW = 8
);

  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic            dout_ready;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic [3:0]      ack;

  // Requesters and the downstream sink drive the bus from this side.
  modport master (
    output req,
    output din,
    output dout_ready,
    input  gnt,
    input  sel,
    input  dout,
    input  dout_valid,
    input  ack
  );

  // The scheduler itself.
  modport slave (
    input  req,
    input  din,
    input  dout_ready,
    output gnt,
    output sel,
    output dout,
    output dout_valid,
    output ack
  );

endinterface

// File: rtl/mux_41_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux between four requesters.
// A grant lasts at most MAX_BEATS accepted beats, or ends early when the
// granted requester drops its request. Every release is followed by one
// IDLE cycle, and the search for the next winner starts one lane past the
// lane that was just released.
module mux_41_rr_sched #(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_41_rr_sched_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int             CW        = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BEATS - 1);

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [DW-1:0]   lanes [4];
  logic            dout_valid;
  logic            transfer;
  logic            last_beat;

  // First set request bit scanning from p upward, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // One-hot decode of a lane index.
  function automatic logic [3:0] lane_onehot(input logic [1:0] idx);
    lane_onehot = 4'b0001 << idx;
  endfunction

  // Split the packed input bus into addressable lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lanes[i] = bus.din[i*DW +: DW];
    end
  end

  // Output path is purely combinational off the registered select, so an
  // asynchronous reset of state_q drops valid and ack immediately.
  assign dout_valid     = (state_q == BUSY) && bus.req[sel_q];
  assign transfer       = dout_valid && bus.dout_ready;
  assign last_beat      = (beat_cnt_q == LAST_BEAT);

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.dout_valid = dout_valid;
  assign bus.dout       = dout_valid ? lanes[sel_q] : '0;
  assign bus.ack        = transfer ? lane_onehot(sel_q) : 4'b0000;

  // Next-state logic: arbitration in IDLE, beat counting and release in BUSY.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d    = BUSY;
          sel_d      = rr_pick(bus.req, ptr_q);
          gnt_d      = lane_onehot(rr_pick(bus.req, ptr_q));
          beat_cnt_d = '0;
        end
      end

      BUSY: begin
        // Release on the final beat of the burst, or when the owner stops
        // requesting. The select is left in place; only the grant clears.
        if ((transfer && last_beat) || !bus.req[sel_q]) begin
          state_d    = IDLE;
          gnt_d      = 4'b0000;
          ptr_d      = sel_q + 2'd1;
          beat_cnt_d = '0;
        end else if (transfer) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State, grant, select, pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Structural invariants of the grant and the counter.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_gnt_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q == 4'b0000) || (gnt_q == lane_onehot(sel_q)));
  a_gnt_iff_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BUSY) == (gnt_q != 4'b0000));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    beat_cnt_q <= LAST_BEAT);

endmodule
